debug_packet_queue: RTL and testbench

Buffers fixed 6-byte debug response packets produced by the emulator debug core and feeds them, one at a time, to the UART packet sender. The block sits directly upstream of the sender. It presents a packet on six parallel byte buses and starts transmission with a toggle on `count`. It then waits on the sender's `complete` level before launching the next packet, so the debug core can issue bursts of responses without tracking UART timing.

---
 rtl/debug_pkt_pkg.sv | 27 ++
 rtl/debug_pkt_fifo.sv | 56 +++++
 rtl/debug_packet_queue.sv | 123 ++++++++++++
 tb/tb_debug_packet_queue.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkt_pkg.sv
// Shared types and constants for the debug packet queue.
// Packet geometry, launch FSM states, settle length, checksum helper.
package debug_pkt_pkg;

  localparam int PKT_BYTES     = 6;
  localparam int PKT_W         = 48;
  localparam int SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT_DONE
  } state_e;

  // XOR of bytes 0..4; byte 5 is the slot the checksum replaces.
  function automatic logic [7:0] pkt_xor(
    input logic [PKT_W-1:0] p
  );
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < PKT_BYTES - 1; i++) begin
      x = x ^ p[i*8 +: 8];
    end
    return x;
  endfunction

endpackage

// File: rtl/debug_pkt_fifo.sv
// DEPTH x 48 packet FIFO with wrapping pointers and an occupancy count.
// Ports: clk, rst, push_i, pop_i, wdata_i -> rdata_o (head), level_o.
module debug_pkt_fifo
  import debug_pkt_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [PKT_W-1:0] wdata_i,
  output logic [PKT_W-1:0] rdata_o,
  output logic [ADDR_W:0]  level_o
);

  logic [PKT_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/debug_packet_queue.sv
// Queues 6-byte debug packets and launches them to the UART sender.
// Ports: push_valid/ready/data in, data0..5 + count toggle out,
// complete from sender, level, sticky overflow.
// Build option PKT_CHECKSUM_EN: data5 carries XOR of bytes 0..4.
module debug_packet_queue
  import debug_pkt_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [PKT_W-1:0] push_data,
  output logic [7:0]       data0,
  output logic [7:0]       data1,
  output logic [7:0]       data2,
  output logic [7:0]       data3,
  output logic [7:0]       data4,
  output logic [7:0]       data5,
  output logic             count,
  input  logic             complete,
  output logic [ADDR_W:0]  level,
  output logic             overflow
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       settle_q, settle_d;
  logic [PKT_W-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             count_d;
  // Deliberately outside reset: a reset must never look like a launch.
  logic             count_q = 1'b0;

  logic             launch;
  logic             push_acc;
  logic [PKT_W-1:0] fifo_head;
  logic [PKT_W-1:0] head_pkt;
  logic [ADDR_W:0]  level_w;

  assign push_ready = (level_w != FULL_LVL);
  assign push_acc   = push_valid & push_ready;

  debug_pkt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_acc),
    .pop_i   (launch),
    .wdata_i (push_data),
    .rdata_o (fifo_head),
    .level_o (level_w)
  );

`ifdef PKT_CHECKSUM_EN
  assign head_pkt = {pkt_xor(fifo_head), fifo_head[39:0]};
`else
  assign head_pkt = fifo_head;
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    data_d   = data_q;
    count_d  = count_q;
    launch   = 1'b0;
    ovf_d    = ovf_q | (push_valid & ~push_ready);
    unique case (state_q)
      IDLE: begin
        if (level_w != '0 && complete) begin
          launch   = 1'b1;
          data_d   = head_pkt;
          count_d  = ~count_q;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      // Sender lowers complete a cycle after the toggle; ignore it here.
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = WAIT_DONE;
        else settle_d = settle_q + 1'b1;
      end
      WAIT_DONE: begin
        if (complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= count_d;
  end

  assign data0    = data_q[7:0];
  assign data1    = data_q[15:8];
  assign data2    = data_q[23:16];
  assign data3    = data_q[31:24];
  assign data4    = data_q[39:32];
  assign data5    = data_q[47:40];
  assign count    = count_q;
  assign level    = level_w;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_debug_packet_queue.sv
// Directed bench for debug_packet_queue with a small UART sender model.
// Tasks per scenario; summary line reports checks and errors.
module tb_debug_packet_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [47:0] push_data = '0;
  logic [7:0]  data0, data1, data2, data3, data4, data5;
  logic        count;
  logic        complete;
  logic [3:0]  level;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic        sender_idle = 1'b1;
  logic        hold_low = 1'b0;
  int          busy_len = 0;
  int          busy_left = 0;
  logic        cnt_prev = 1'b0;
  logic [47:0] launched [$];

  assign complete = sender_idle & ~hold_low;

  always #5 clk = ~clk;

  debug_packet_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .data4      (data4),
    .data5      (data5),
    .count      (count),
    .complete   (complete),
    .level      (level),
    .overflow   (overflow)
  );

  function automatic logic [47:0] exp_pkt(input logic [47:0] p);
`ifdef PKT_CHECKSUM_EN
    return {p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24] ^ p[39:32], p[39:0]};
`else
    return p;
`endif
  endfunction

  function automatic logic [47:0] bus();
    return {data5, data4, data3, data2, data1, data0};
  endfunction

  // Sender model: records each launch, goes busy for busy_len cycles.
  always @(posedge clk) begin
    #1;
    if (count !== cnt_prev) begin
      launched.push_back(bus());
      checks++;
      if (complete !== 1'b1) begin
        errors++;
        $display("FAIL launch_gate: launched with complete=%b, need 1",
                 complete);
      end
      if (busy_len > 0) begin
        sender_idle = 1'b0;
        busy_left = busy_len;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) sender_idle = 1'b1;
    end
    cnt_prev = count;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    push_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (level !== 4'd0) begin
      errors++; $display("FAIL reset_level: got %0d want 0", level);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b want 0", overflow);
    end
    checks++;
    if (push_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", push_ready);
    end
    checks++;
    if (bus() !== 48'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", bus());
    end
    checks++;
    if (count !== 1'b0) begin
      errors++; $display("FAIL reset_count: got %b want 0", count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic c0;
    logic [47:0] p;
    p = 48'h060504030201;
    busy_len = 3;
    launched.delete();
    c0 = count;
    @(negedge clk);
    push_valid = 1'b1;
    push_data = p;
    @(posedge clk); #1;
    checks++;
    if (level !== 4'd1 || count !== c0) begin
      errors++;
      $display("FAIL single_push: level=%0d count=%b want 1/%b",
               level, count, c0);
    end
    @(negedge clk);
    push_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (count !== ~c0) begin
      errors++; $display("FAIL single_toggle: got %b want %b", count, ~c0);
    end
    checks++;
    if (bus() !== exp_pkt(p)) begin
      errors++;
      $display("FAIL single_data: got %h want %h", bus(), exp_pkt(p));
    end
    checks++;
    if (level !== 4'd0) begin
      errors++; $display("FAIL single_level: got %0d want 0", level);
    end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (launched.size() != 1 || count !== ~c0) begin
      errors++;
      $display("FAIL single_once: launches=%0d count=%b want 1/%b",
               launched.size(), count, ~c0);
    end
  endtask

  task automatic test_burst();
    logic [47:0] pk [3];
    pk[0] = 48'h111213141516;
    pk[1] = 48'hA1A2A3A4A5A6;
    pk[2] = 48'h0F1E2D3C4B5A;
    busy_len = 20;
    launched.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_valid = 1'b1;
      push_data = pk[i];
    end
    @(negedge clk);
    push_valid = 1'b0;
    for (int c = 0; c < 200 && launched.size() < 3; c++) @(posedge clk);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (launched.size() != 3) begin
      errors++;
      $display("FAIL burst_count: got %0d want 3", launched.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (launched[i] !== exp_pkt(pk[i])) begin
          errors++;
          $display("FAIL burst_order[%0d]: got %h want %h",
                   i, launched[i], exp_pkt(pk[i]));
        end
      end
    end
  endtask

  task automatic test_full();
    logic [47:0] fp [9];
    logic c0;
    for (int i = 0; i < 9; i++) fp[i] = {16'hF00D, 24'h0, 8'(i + 1)};
    busy_len = 2;
    launched.delete();
    @(negedge clk);
    hold_low = 1'b1;
    c0 = count;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      push_valid = 1'b1;
      push_data = fp[i];
      @(posedge clk); #1;
      if (i == 7) begin
        checks++;
        if (push_ready !== 1'b0 || level !== 4'd8 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL full_8th: ready=%b level=%0d ovf=%b want 0/8/0",
                   push_ready, level, overflow);
        end
      end
      if (i == 8) begin
        checks++;
        if (overflow !== 1'b1 || level !== 4'd8) begin
          errors++;
          $display("FAIL full_9th: ovf=%b level=%0d want 1/8",
                   overflow, level);
        end
      end
    end
    @(negedge clk);
    push_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (count !== c0 || launched.size() != 0) begin
      errors++;
      $display("FAIL full_hold: count=%b launches=%0d want %b/0",
               count, launched.size(), c0);
    end
    @(negedge clk);
    hold_low = 1'b0;
    for (int c = 0; c < 200 && launched.size() < 8; c++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (launched.size() != 8) begin
      errors++;
      $display("FAIL full_drain: got %0d want 8", launched.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (launched[i] !== exp_pkt(fp[i])) begin
          errors++;
          $display("FAIL full_order[%0d]: got %h want %h",
                   i, launched[i], exp_pkt(fp[i]));
        end
      end
    end
    checks++;
    if (level !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_end: level=%0d ovf=%b want 0/1", level, overflow);
    end
  endtask

  task automatic test_wrap();
    logic [47:0] wp [20];
    int idx;
    for (int i = 0; i < 20; i++) begin
      wp[i] = {8'(i + 8'h30), 8'(i * 3), 24'hC0FFEE, 8'(i)};
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL wrap_clear: ovf=%b want 0", overflow);
    end
    busy_len = 0;
    launched.delete();
    idx = 0;
    for (int c = 0; c < 400 && launched.size() < 20; c++) begin
      @(negedge clk);
      if (idx < 20 && push_ready) begin
        push_valid = 1'b1;
        push_data = wp[idx];
        idx++;
      end else begin
        push_valid = 1'b0;
      end
    end
    @(negedge clk);
    push_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (launched.size() != 20) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 20", launched.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (launched[i] !== exp_pkt(wp[i])) begin
          errors++;
          $display("FAIL wrap_order[%0d]: got %h want %h",
                   i, launched[i], exp_pkt(wp[i]));
        end
      end
    end
    checks++;
    if (level !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: level=%0d ovf=%b want 0/0", level, overflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] rp [3];
    logic cm;
    rp[0] = 48'h313233343536;
    rp[1] = 48'h414243444546;
    rp[2] = 48'h515253545556;
    busy_len = 20;
    launched.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_valid = 1'b1;
      push_data = rp[i];
    end
    @(posedge clk); #1;
    cm = count;
    checks++;
    if (level !== 4'd2 || launched.size() != 1) begin
      errors++;
      $display("FAIL mid_setup: level=%0d launches=%0d want 2/1",
               level, launched.size());
    end
    @(negedge clk);
    push_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (level !== 4'd0 || bus() !== 48'h0 || count !== cm) begin
      errors++;
      $display("FAIL mid_reset: level=%0d data=%h count=%b want 0/0/%b",
               level, bus(), count, cm);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (launched.size() != 1 || count !== cm || level !== 4'd0) begin
      errors++;
      $display("FAIL mid_after: launches=%0d count=%b level=%0d want 1/%b/0",
               launched.size(), count, level, cm);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
